// File: rtl/board_state_ctrl.sv
// Board-state and turn controller for a 15x15 five-in-a-row game.
// It places stones, rejects illegal moves, and records the result reported by the external win checker.
module board_state_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         move_valid,
  input  logic [3:0]   move_row,
  input  logic [3:0]   move_col,
  output logic         move_ready,
  input  logic         win_check,
  output logic [224:0] chk_board,
  output logic [3:0]   chk_row,
  output logic [3:0]   chk_col,
  output logic [224:0] black_board,
  output logic [224:0] white_board,
  output logic         turn,
  output logic         move_ack,
  output logic         move_err,
  output logic         game_over,
  output logic [1:0]   winner,
  output logic [7:0]   move_count
);

  localparam int         CELLS     = 225;
  localparam logic [7:0] MAX_MOVES = 8'd225;

  typedef enum logic [1:0] {IDLE, CHECK, OVER} state_t;

  state_t         state_reg;
  logic [224:0]   black_reg;
  logic [224:0]   white_reg;
  logic           turn_reg;
  logic [3:0]     chk_row_reg;
  logic [3:0]     chk_col_reg;
  logic [7:0]     count_reg;
  logic           ack_reg;
  logic           err_reg;
  logic           over_reg;
  logic [1:0]     winner_reg;

  logic [7:0]     move_idx;
  logic [224:0]   move_mask;
  logic [224:0]   occupied;
  logic           move_legal;

  // Out-of-range coordinates may alias onto a real cell; the range test below rejects them anyway.
  assign move_idx = ({4'd0, move_row} * 8'd15) + {4'd0, move_col};

  genvar gi;
  generate
    for (gi = 0; gi < CELLS; gi++) begin : g_cell
      assign move_mask[gi] = (move_idx == 8'(gi));
      assign occupied[gi]  = black_reg[gi] | white_reg[gi];
    end
  endgenerate

  assign move_legal = (move_row < 4'd15) && (move_col < 4'd15) &&
                      ((occupied & move_mask) == '0) && (count_reg < MAX_MOVES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      black_reg   <= '0;
      white_reg   <= '0;
      turn_reg    <= 1'b0;
      chk_row_reg <= '0;
      chk_col_reg <= '0;
      count_reg   <= '0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      over_reg    <= 1'b0;
      winner_reg  <= 2'b00;
    end else begin
      ack_reg <= 1'b0;
      err_reg <= 1'b0;
      if (clear) begin
        state_reg   <= IDLE;
        black_reg   <= '0;
        white_reg   <= '0;
        turn_reg    <= 1'b0;
        chk_row_reg <= '0;
        chk_col_reg <= '0;
        count_reg   <= '0;
        over_reg    <= 1'b0;
        winner_reg  <= 2'b00;
      end else begin
        case (state_reg)
          IDLE: begin
            if (move_valid) begin
              if (move_legal) begin
                if (turn_reg) white_reg <= white_reg | move_mask;
                else          black_reg <= black_reg | move_mask;
                chk_row_reg <= move_row;
                chk_col_reg <= move_col;
                count_reg   <= count_reg + 8'd1;
                state_reg   <= CHECK;
              end else begin
                err_reg <= 1'b1;
              end
            end
          end
          CHECK: begin
            ack_reg <= 1'b1;
            if (win_check) begin
              winner_reg <= turn_reg ? 2'b10 : 2'b01;
              over_reg   <= 1'b1;
              state_reg  <= OVER;
            end else if (count_reg == MAX_MOVES) begin
              winner_reg <= 2'b11;
              over_reg   <= 1'b1;
              state_reg  <= OVER;
            end else begin
              turn_reg  <= ~turn_reg;
              state_reg <= IDLE;
            end
          end
          OVER: begin
            state_reg <= OVER;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign move_ready  = (state_reg == IDLE);
  assign chk_board   = turn_reg ? white_reg : black_reg;
  assign chk_row     = chk_row_reg;
  assign chk_col     = chk_col_reg;
  assign black_board = black_reg;
  assign white_board = white_reg;
  assign turn        = turn_reg;
  assign move_ack    = ack_reg;
  assign move_err    = err_reg;
  assign game_over   = over_reg;
  assign winner      = winner_reg;
  assign move_count  = count_reg;

endmodule
